decode_issue: RTL
=================

Name: decode_issue

Overview:
- Front end of the execute interface: accepts raw 32-bit RV32I instructions and decodes OP and OP-IMM into the `alu_instr_t` operation encoding.
- Owns the 32x32 architectural register file and reads operands from it.
- Tracks outstanding destination registers with a scoreboard and holds hazards.
- Presents one registered operand bundle per instruction to the ALU stage over a valid/ready handshake; writeback returns through a dedicated write port.

Parameters:
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.
- XLEN, 32, register and operand width.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_instr  in  32  raw instruction word
- in_ready  out  1  decode accepts in_instr this cycle
- out_valid  out  1  operand bundle valid
- out_ready  in  1  ALU stage consumes bundle
- out_instr  out  alu_instr_t  decoded ALU operation
- out_is_imm  out  1  operation is OP-IMM
- out_rs1_data  out  XLEN  rs1 operand
- out_rs2_data  out  XLEN  rs2 operand; for OP-IMM, equals out_imm_i
- out_imm_i  out  XLEN  sign-extended I-immediate, instr[31:20]
- out_rd  out  5  destination register; 0 when illegal
- out_illegal  out  1  instruction not OP/OP-IMM, or bad funct7
- wb_en  in  1  writeback strobe
- wb_addr  in  5  writeback register
- wb_data  in  XLEN  writeback value

Behaviour:
- Reset (synchronous, active-high): out_valid=0; out_instr=i_ADD; all other outputs 0; scoreboard cleared; all registers 0. A reset asserted mid-operation drops the held bundle.
- Output stage is a single register: in_ready = !out_valid || out_ready, and not hazard-stalled.
- Accept occurs when in_valid && in_ready. Bundle is registered at accept; out_valid rises the next cycle. Latency is 1 cycle.
- A held bundle is stable until out_ready.
- Decode:
  - opcode 0110011: funct7 0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3; funct7 0100000 with funct3 000 selects SUB, with funct3 101 selects SRA; any other funct7 is illegal.
  - opcode 0010011: ADDI/SLTI/SLTIU/XORI/ORI/ANDI by funct3. SLLI/SRLI require imm[11:5]=0000000. SRAI requires imm[11:5]=0100000; otherwise illegal. out_rs2_data=imm_i, so shamt = imm[4:0].
  - Any other opcode is illegal.
- Illegal instruction: accepted normally; out_illegal=1, out_instr=i_ADD, out_rd=0, scoreboard untouched.
- Register file:
  - x0 reads 0 and writes to it are ignored.
  - wb_en writes on the clock edge.
  - wb_en with wb_addr=0 is ignored.
- Scoreboard:
  - One busy bit per register. It is set at accept for a legal instruction with rd!=0, and cleared by wb_en to that address.
  - Same-cycle set and clear of the same register: set wins.
- Hazard stall (in_ready=0):
  - a read source (rs1, and rs2 for OP only) is busy and not cleared this cycle (see feature), or
  - rd is busy and wb_en does not target it this cycle (WAW).

Optional Feature:
DECODE_BYPASS_EN
- Defined: a busy source whose wb_en/wb_addr matches this cycle is not a hazard; the operand takes wb_data (write-through).
- Undefined: any busy source stalls; the instruction is accepted the cycle after writeback, with the operand read from the register file.

Test Plan:
- Reset, then 0x00500093 (ADDI x1,x0,5) with out_ready=1 -> next cycle out_valid=1, out_instr=i_ADD, out_is_imm=1, out_rs1_data=0, out_imm_i=5, out_rd=1; x1 busy.
- Follow immediately with 0x00108133 (ADD x2,x1,x1), no wb -> in_ready=0; wb_en x1=5 -> with bypass accepted that cycle with rs1=rs2=5; without bypass accepted one cycle later.
- 0x401101B3 (SUB x3,x2,x1) with x2=10, x1=5 -> out_instr=i_SUB, rs1=10, rs2=5, out_rd=3.
- 0x4021D213 (SRAI x4,x3,2) -> out_instr=i_SRA, out_rs2_data=0x402, out_is_imm=1. Changing bit 30 gives 0x0021D213 -> i_SRL.
- 0x0000A083 (LW) -> out_illegal=1, out_rd=0, no busy bit set. Hold out_ready=0 for 3 cycles -> bundle stable, in_ready=0.
- Assert rst while out_valid=1 -> next cycle out_valid=0, scoreboard clear, x1 reads 0.

Source files
------------

// File: rtl/decode_issue_pkg.sv
// Shared types for the decode/issue stage.
// alu_instr_t : ALU operation encoding carried from decode to the ALU stage.
package decode_issue_pkg;

    typedef enum logic [3:0] {
        i_ADD  = 4'd0,
        i_SUB  = 4'd1,
        i_SLL  = 4'd2,
        i_SLT  = 4'd3,
        i_SLTU = 4'd4,
        i_XOR  = 4'd5,
        i_SRL  = 4'd6,
        i_SRA  = 4'd7,
        i_OR   = 4'd8,
        i_AND  = 4'd9
    } alu_instr_t;

endpackage

// File: rtl/decode_issue.sv
// decode_issue: RV32I OP/OP-IMM decoder, register file, scoreboard and
// single-entry registered issue stage.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : instruction handshake from fetch; in_instr is the raw word
//   out_valid/out_ready : operand bundle handshake to the ALU stage
//   out_instr, out_is_imm, out_rs1_data, out_rs2_data, out_imm_i, out_rd,
//   out_illegal       : registered operand bundle
//   wb_en, wb_addr, wb_data : register file write port (writeback)
//
// Optional feature macro: DECODE_BYPASS_EN
//   defined   : a busy source being written back this cycle is forwarded
//               from wb_data instead of stalling
//   undefined : any busy source stalls until the cycle after its writeback
//
// Illegal instructions are accepted and issue a bundle with out_illegal=1,
// out_instr=i_ADD and all operand/immediate/rd fields zero.
module decode_issue
    import decode_issue_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    parameter int unsigned XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output alu_instr_t       out_instr,
    output logic             out_is_imm,
    output logic [XLEN-1:0]  out_rs1_data,
    output logic [XLEN-1:0]  out_rs2_data,
    output logic [XLEN-1:0]  out_imm_i,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // Architectural state
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;

    // Output bundle register
    logic             out_valid_q, out_valid_d;
    alu_instr_t       out_instr_q, out_instr_d;
    logic             out_is_imm_q, out_is_imm_d;
    logic [XLEN-1:0]  out_rs1_q, out_rs1_d;
    logic [XLEN-1:0]  out_rs2_q, out_rs2_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [4:0]       out_rd_q, out_rd_d;
    logic             out_illegal_q, out_illegal_d;

    // Instruction fields
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] imm_i;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];
    assign imm_i  = XLEN'($signed(in_instr[31:20]));

    logic       is_op, is_opimm, dec_legal;
    alu_instr_t dec_op;

    // Decode OP / OP-IMM; dec_op stays i_ADD whenever the word is illegal
    always_comb begin
        is_op     = (opcode == OPC_OP);
        is_opimm  = (opcode == OPC_OP_IMM);
        dec_op    = i_ADD;
        dec_legal = 1'b0;
        if (is_op) begin
            if (funct7 == F7_BASE) begin
                dec_legal = 1'b1;
                case (funct3)
                    3'd0: dec_op = i_ADD;
                    3'd1: dec_op = i_SLL;
                    3'd2: dec_op = i_SLT;
                    3'd3: dec_op = i_SLTU;
                    3'd4: dec_op = i_XOR;
                    3'd5: dec_op = i_SRL;
                    3'd6: dec_op = i_OR;
                    3'd7: dec_op = i_AND;
                endcase
            end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
                dec_legal = 1'b1;
                dec_op    = i_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
                dec_legal = 1'b1;
                dec_op    = i_SRA;
            end
        end else if (is_opimm) begin
            case (funct3)
                3'd0: begin dec_legal = 1'b1; dec_op = i_ADD;  end
                3'd2: begin dec_legal = 1'b1; dec_op = i_SLT;  end
                3'd3: begin dec_legal = 1'b1; dec_op = i_SLTU; end
                3'd4: begin dec_legal = 1'b1; dec_op = i_XOR;  end
                3'd6: begin dec_legal = 1'b1; dec_op = i_OR;   end
                3'd7: begin dec_legal = 1'b1; dec_op = i_AND;  end
                3'd1: begin
                    if (funct7 == F7_BASE) begin
                        dec_legal = 1'b1;
                        dec_op    = i_SLL;
                    end
                end
                3'd5: begin
                    if (funct7 == F7_BASE) begin
                        dec_legal = 1'b1;
                        dec_op    = i_SRL;
                    end else if (funct7 == F7_ALT) begin
                        dec_legal = 1'b1;
                        dec_op    = i_SRA;
                    end
                end
            endcase
        end
    end

    logic            wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
    logic            stall_rs1, stall_rs2, stall_rd, hazard, accept;
    logic [XLEN-1:0] rs1_val, rs2_val;

    // Hazard detection and operand read; x0 is never busy and always reads 0
    always_comb begin
        wb_hit_rs1 = wb_en && (wb_addr == rs1) && (rs1 != 5'd0);
        wb_hit_rs2 = wb_en && (wb_addr == rs2) && (rs2 != 5'd0);
        wb_hit_rd  = wb_en && (wb_addr == rd);
        rs1_val    = regs_q[rs1];
        rs2_val    = regs_q[rs2];
`ifdef DECODE_BYPASS_EN
        stall_rs1  = busy_q[rs1] && !wb_hit_rs1;
        stall_rs2  = is_op && busy_q[rs2] && !wb_hit_rs2;
        if (wb_hit_rs1) rs1_val = wb_data;
        if (wb_hit_rs2) rs2_val = wb_data;
`else
        stall_rs1  = busy_q[rs1];
        stall_rs2  = is_op && busy_q[rs2];
`endif
        stall_rd   = busy_q[rd] && !wb_hit_rd;
        hazard     = dec_legal && (stall_rs1 || stall_rs2 || stall_rd);
        in_ready   = (!out_valid_q || out_ready) && !hazard;
        accept     = in_valid && in_ready;
    end

    // Scoreboard next state: writeback clears, a same-cycle accept sets and wins
    always_comb begin
        busy_d = busy_q;
        if (wb_en) busy_d[wb_addr] = 1'b0;
        if (accept && dec_legal) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Output bundle next state; held until consumed
    always_comb begin
        out_valid_d   = out_valid_q && !out_ready;
        out_instr_d   = out_instr_q;
        out_is_imm_d  = out_is_imm_q;
        out_rs1_d     = out_rs1_q;
        out_rs2_d     = out_rs2_q;
        out_imm_d     = out_imm_q;
        out_rd_d      = out_rd_q;
        out_illegal_d = out_illegal_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            out_instr_d   = dec_op;
            out_illegal_d = !dec_legal;
            out_is_imm_d  = dec_legal && is_opimm;
            out_rs1_d     = dec_legal ? rs1_val : '0;
            out_rs2_d     = !dec_legal ? '0 : (is_opimm ? imm_i : rs2_val);
            out_imm_d     = dec_legal ? imm_i : '0;
            out_rd_d      = dec_legal ? rd : 5'd0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_instr_q   <= i_ADD;
            out_is_imm_q  <= 1'b0;
            out_rs1_q     <= '0;
            out_rs2_q     <= '0;
            out_imm_q     <= '0;
            out_rd_q      <= 5'd0;
            out_illegal_q <= 1'b0;
            busy_q        <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_is_imm_q  <= out_is_imm_d;
            out_rs1_q     <= out_rs1_d;
            out_rs2_q     <= out_rs2_d;
            out_imm_q     <= out_imm_d;
            out_rd_q      <= out_rd_d;
            out_illegal_q <= out_illegal_d;
            busy_q        <= busy_d;
            if (wb_en && wb_addr != 5'd0) regs_q[wb_addr] <= wb_data;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_is_imm   = out_is_imm_q;
    assign out_rs1_data = out_rs1_q;
    assign out_rs2_data = out_rs2_q;
    assign out_imm_i    = out_imm_q;
    assign out_rd       = out_rd_q;
    assign out_illegal  = out_illegal_q;

endmodule
